// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_spram data memory: write-mode and
// controller state encodings, byte-lane parity and lane-count derivation.
package dmem_pkg;

    typedef enum logic [1:0] {
        WM_NORMAL      = 2'd0,
        WM_TRANSPARENT = 2'd1,
        WM_RBW         = 2'd2
    } wmode_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    function automatic int be_width(input int data_w, input int byte_w);
        return data_w / byte_w;
    endfunction

    // Even parity over one lane; 8-bit lanes arrive zero-extended to 9 bits.
    function automatic logic lane_parity(input logic [8:0] lane);
        return ^lane;
    endfunction

endpackage

// File: rtl/dmem_spram_array.sv
// Behavioural byte-enable storage array. Reads are combinational so the
// caller can check parity before its own response register.
module dmem_spram_array
    import dmem_pkg::*;
#(
    parameter int     ADDR_WIDTH = 13,
    parameter int     LANES      = 4,
    parameter int     LANE_W     = 8,
    parameter wmode_e WMODE      = WM_TRANSPARENT
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [ADDR_WIDTH-1:0]    addr_i,
    input  logic [LANES*LANE_W-1:0]  wdata_i,
    input  logic [LANES-1:0]         be_i,
    output logic [LANES*LANE_W-1:0]  rdata_o
);

    localparam int DEPTH  = 2**ADDR_WIDTH;
    localparam int WORD_W = LANES * LANE_W;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] old_s;
    logic [WORD_W-1:0] merged_s;

    // Merge enabled write lanes over the currently stored word.
    always_comb begin
        old_s    = mem_q[addr_i];
        merged_s = old_s;
        for (int i = 0; i < LANES; i++) begin
            if (be_i[i]) begin
                merged_s[i*LANE_W +: LANE_W] = wdata_i[i*LANE_W +: LANE_W];
            end else begin
                merged_s[i*LANE_W +: LANE_W] = old_s[i*LANE_W +: LANE_W];
            end
        end
    end

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= merged_s;
        end
    end

    // Read port: transparent mode returns the merged word during a write.
    always_comb begin
        case (WMODE)
            WM_TRANSPARENT: rdata_o = we_i ? merged_s : old_s;
            WM_RBW:         rdata_o = old_s;
            WM_NORMAL:      rdata_o = old_s;
            default:        rdata_o = old_s;
        endcase
    end

endmodule

// File: rtl/dmem_spram.sv
// Single-port LSU data memory with valid/ready requests, post-reset zero-fill
// sweep and optional output register. Define DMEM_PARITY_EN for lane parity.
module dmem_spram
    import dmem_pkg::*;
#(
    parameter int    ADDR_WIDTH     = 13,
    parameter int    DATA_WIDTH     = 32,
    parameter int    BYTE_SIZE      = 8,
    parameter int    BE_WIDTH       = be_width(DATA_WIDTH, BYTE_SIZE),
    parameter string WRITE_MODE     = "TRANSPARENT_WRITE",
    parameter int    OUTPUT_REG     = 0,
    parameter int    CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [BE_WIDTH-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  clr_busy,
    output logic                  par_err
);

`ifdef DMEM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int LANE_W = BYTE_SIZE + PAR_W;
    localparam int WORD_W = BE_WIDTH * LANE_W;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;
    localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    localparam wmode_e WMODE = (WRITE_MODE == "NORMAL_WRITE")      ? WM_NORMAL :
                               (WRITE_MODE == "READ_BEFORE_WRITE") ? WM_RBW    :
                                                                     WM_TRANSPARENT;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  req_ready_q, clr_busy_q;
    logic                  acc_s, rsp_s, perr_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic [WORD_W-1:0]     mem_wdata_s, mem_rdata_s, wr_word_s;
    logic [BE_WIDTH-1:0]   mem_be_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic                  s1_valid_q, s1_perr_q;
    logic [DATA_WIDTH-1:0] s1_data_q;

    assign acc_s = req_valid && req_ready_q;
    assign rsp_s = acc_s && (!req_we || (WMODE != WM_NORMAL));

    // Sweep/run controller next state; an illegal state restarts the sweep.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                if (clr_cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Controller state and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            clr_cnt_q   <= '0;
            req_ready_q <= (RST_STATE == ST_RUN);
            clr_busy_q  <= (RST_STATE == ST_CLEAR);
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            req_ready_q <= (state_d == ST_RUN);
            clr_busy_q  <= (state_d == ST_CLEAR);
        end
    end

    // Pack request bytes into storage lanes, adding parity when enabled.
    always_comb begin
        wr_word_s = '0;
        for (int i = 0; i < BE_WIDTH; i++) begin
            wr_word_s[i*LANE_W +: BYTE_SIZE] = req_wdata[i*BYTE_SIZE +: BYTE_SIZE];
`ifdef DMEM_PARITY_EN
            wr_word_s[i*LANE_W + BYTE_SIZE] = lane_parity(9'(req_wdata[i*BYTE_SIZE +: BYTE_SIZE]));
`endif
        end
    end

    // Array port is owned by the sweep until it finishes.
    always_comb begin
        if (state_q == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = clr_cnt_q;
            mem_wdata_s = '0;
            mem_be_s    = '1;
        end else begin
            mem_we_s    = acc_s && req_we;
            mem_addr_s  = req_addr;
            mem_wdata_s = wr_word_s;
            mem_be_s    = req_be;
        end
    end

    dmem_spram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LANES      (BE_WIDTH),
        .LANE_W     (LANE_W),
        .WMODE      (WMODE)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we_s),
        .addr_i  (mem_addr_s),
        .wdata_i (mem_wdata_s),
        .be_i    (mem_be_s),
        .rdata_o (mem_rdata_s)
    );

    // Unpack read lanes and check stored parity ahead of the response register.
    always_comb begin
        rd_data_s = '0;
        perr_s    = 1'b0;
        for (int i = 0; i < BE_WIDTH; i++) begin
            rd_data_s[i*BYTE_SIZE +: BYTE_SIZE] = mem_rdata_s[i*LANE_W +: BYTE_SIZE];
`ifdef DMEM_PARITY_EN
            if (mem_rdata_s[i*LANE_W + BYTE_SIZE] !=
                lane_parity(9'(mem_rdata_s[i*LANE_W +: BYTE_SIZE]))) begin
                perr_s = 1'b1;
            end else begin
                perr_s = perr_s;
            end
`endif
        end
    end

    // First response stage; data holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_perr_q  <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= rsp_s;
            s1_perr_q  <= rsp_s && perr_s;
            if (rsp_s) begin
                s1_data_q <= rd_data_s;
            end
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic                  s2_valid_q, s2_perr_q;
            logic [DATA_WIDTH-1:0] s2_data_q;

            // Optional second response stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid_q <= 1'b0;
                    s2_perr_q  <= 1'b0;
                    s2_data_q  <= '0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    s2_perr_q  <= s1_perr_q;
                    if (s1_valid_q) begin
                        s2_data_q <= s1_data_q;
                    end
                end
            end

            assign rsp_valid = s2_valid_q;
            assign rsp_rdata = s2_data_q;
            assign par_err   = s2_perr_q;
        end else begin : g_no_out_reg
            assign rsp_valid = s1_valid_q;
            assign rsp_rdata = s1_data_q;
            assign par_err   = s1_perr_q;
        end
    endgenerate

    assign req_ready = req_ready_q;
    assign clr_busy  = clr_busy_q;

endmodule

// File: tb/tb_dmem_spram.sv
// Directed bench for dmem_spram with 16-word depth: one instance per write
// mode, one with the output register and one without the reset sweep.
module tb_dmem_spram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        t_rdy, t_v, t_busy, t_pe;  logic [31:0] t_d;
    logic        n_rdy, n_v, n_busy, n_pe;  logic [31:0] n_d;
    logic        r_rdy, r_v, r_busy, r_pe;  logic [31:0] r_d;
    logic        o_rdy, o_v, o_busy, o_pe;  logic [31:0] o_d;
    logic        z_rdy, z_v, z_busy, z_pe;  logic [31:0] z_d;

    int          checks   = 0;
    int          failures = 0;
    logic        o_ev;
    logic [31:0] o_ed;

    always #5 clk = ~clk;

    dmem_spram #(.ADDR_WIDTH(4), .WRITE_MODE("TRANSPARENT_WRITE"), .OUTPUT_REG(0)) u_t (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(t_rdy), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(t_v),
        .rsp_rdata(t_d), .clr_busy(t_busy), .par_err(t_pe));
    dmem_spram #(.ADDR_WIDTH(4), .WRITE_MODE("NORMAL_WRITE"), .OUTPUT_REG(0)) u_n (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(n_rdy), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(n_v),
        .rsp_rdata(n_d), .clr_busy(n_busy), .par_err(n_pe));
    dmem_spram #(.ADDR_WIDTH(4), .WRITE_MODE("READ_BEFORE_WRITE"), .OUTPUT_REG(0)) u_r (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(r_rdy), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(r_v),
        .rsp_rdata(r_d), .clr_busy(r_busy), .par_err(r_pe));
    dmem_spram #(.ADDR_WIDTH(4), .WRITE_MODE("TRANSPARENT_WRITE"), .OUTPUT_REG(1)) u_o (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(o_rdy), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(o_v),
        .rsp_rdata(o_d), .clr_busy(o_busy), .par_err(o_pe));
    dmem_spram #(.ADDR_WIDTH(4), .CLEAR_ON_RESET(0)) u_z (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(z_rdy), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(z_v),
        .rsp_rdata(z_d), .clr_busy(z_busy), .par_err(z_pe));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request cycle; o (2-cycle latency) is expected to show the previous t response.
    task automatic step(input string tag, input logic vld, input logic we, input logic [3:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic vt, input logic [31:0] dt, input logic vn, input logic [31:0] dn,
                        input logic vr, input logic [31:0] dr);
        req_valid = vld; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_val({tag, "_t"}, {t_pe, t_v, t_d}, {1'b0, vt, dt});
        check_val({tag, "_n"}, {n_pe, n_v, n_d}, {1'b0, vn, dn});
        check_val({tag, "_r"}, {r_pe, r_v, r_d}, {1'b0, vr, dr});
        check_val({tag, "_o"}, {o_pe, o_v, o_d}, {1'b0, o_ev, o_ed});
        o_ev = vt;
        if (vt) o_ed = dt;
    endtask

    task automatic sweep_check(input string tag);
        int cyc = 0;
        int pulses = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (t_v || n_v || r_v || o_v) pulses++;
        end while (t_busy && cyc < 64);
        check_val({tag, "_len"}, 64'(cyc), 64'd16);
        check_val({tag, "_rsp"}, 64'(pulses), 64'd0);
        check_val({tag, "_rdy"}, {60'd0, t_rdy, o_rdy, t_busy, o_busy}, {60'd0, 4'b1100});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 4'd0;
        req_wdata = 32'd0; req_be = 4'd0; o_ev = 1'b0; o_ed = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_t", {t_rdy, t_busy, t_v, t_pe, t_d}, {4'b0100, 32'd0});
        check_val("rst_o", {o_rdy, o_busy, o_v, o_pe, o_d}, {4'b0100, 32'd0});
        check_val("rst_noclr", {z_rdy, z_busy, z_v, z_pe, z_d}, {4'b1000, 32'd0});
        rst_n = 1'b1;
        sweep_check("sweep1");

        for (int i = 0; i < 16; i++)
            step("rd_zero", 1'b1, 1'b0, 4'(i), 32'd0, 4'd0,
                 1'b1, 32'd0, 1'b1, 32'd0, 1'b1, 32'd0);

        step("wr_full", 1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 4'b1111,
             1'b1, 32'hDEADBEEF, 1'b0, 32'd0, 1'b1, 32'd0);
        step("wr_lane", 1'b1, 1'b1, 4'd5, 32'h000000AA, 4'b0001,
             1'b1, 32'hDEADBEAA, 1'b0, 32'd0, 1'b1, 32'hDEADBEEF);
        step("rd5", 1'b1, 1'b0, 4'd5, 32'd0, 4'd0,
             1'b1, 32'hDEADBEAA, 1'b1, 32'hDEADBEAA, 1'b1, 32'hDEADBEAA);
        step("wr_nobe", 1'b1, 1'b1, 4'd5, 32'hFFFFFFFF, 4'b0000,
             1'b1, 32'hDEADBEAA, 1'b0, 32'hDEADBEAA, 1'b1, 32'hDEADBEAA);
        step("idle", 1'b0, 1'b0, 4'd0, 32'd0, 4'd0,
             1'b0, 32'hDEADBEAA, 1'b0, 32'hDEADBEAA, 1'b0, 32'hDEADBEAA);
        step("rd5b", 1'b1, 1'b0, 4'd5, 32'd0, 4'd0,
             1'b1, 32'hDEADBEAA, 1'b1, 32'hDEADBEAA, 1'b1, 32'hDEADBEAA);

        for (int i = 0; i < 16; i++)
            step("wr_pat", 1'b1, 1'b1, 4'(i), 32'h01010101 * 32'(i), 4'b1111,
                 1'b1, 32'h01010101 * 32'(i), 1'b0, 32'hDEADBEAA,
                 1'b1, (i == 5) ? 32'hDEADBEAA : 32'd0);
        for (int i = 0; i < 16; i++)
            step("rd_pat", 1'b1, 1'b0, 4'(i), 32'd0, 4'd0,
                 1'b1, 32'h01010101 * 32'(i), 1'b1, 32'h01010101 * 32'(i),
                 1'b1, 32'h01010101 * 32'(i));

        // Reset while a response is still in flight in the output-register instance.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_val("pre_rst_t", {t_v, t_d}, {1'b1, 32'h03030303});
        rst_n = 1'b0;
        #1;
        check_val("rst_drop_o", {o_rdy, o_busy, o_v, o_pe, o_d}, {4'b0100, 32'd0});
        check_val("rst_drop_t", {t_rdy, t_busy, t_v, t_pe, t_d}, {4'b0100, 32'd0});
        o_ev = 1'b0; o_ed = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check_val("mid_sweep", {t_busy, t_rdy}, 2'b10);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sweep_check("sweep2");
        step("rd3_clr", 1'b1, 1'b0, 4'd3, 32'd0, 4'd0,
             1'b1, 32'd0, 1'b1, 32'd0, 1'b1, 32'd0);
        step("idle2", 1'b0, 1'b0, 4'd0, 32'd0, 4'd0,
             1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);

`ifdef DMEM_PARITY_EN
        step("wr3", 1'b1, 1'b1, 4'd3, 32'h03030303, 4'b1111,
             1'b1, 32'h03030303, 1'b0, 32'd0, 1'b1, 32'd0);
        u_t.u_array.mem_q[3][0] = ~u_t.u_array.mem_q[3][0];
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_val("perr_set", {t_pe, t_v, t_d}, {1'b1, 1'b1, 32'h03030302});
        u_t.u_array.mem_q[3][0] = ~u_t.u_array.mem_q[3][0];
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_val("perr_clr", {t_pe, t_v, t_d}, {1'b0, 1'b1, 32'h03030303});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
